frame_mapper: RTL

Parametrised successor to the fixed-geometry frame controller: owns its own row/column counters and builds a continuous byte-wide frame stream on the sender map path. It inserts the FAS pattern, zero overhead, an optional MFAS byte and a zero stuff column, and pulls client payload through a valid/ready handshake into every payload slot. Frame timing never stalls. A missing client byte becomes a zero byte plus an underrun flag.

---
 rtl/frame_mapper_if.sv | 26 ++
 rtl/frame_mapper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/frame_mapper_if.sv
// Client payload handshake and framed output stream of frame_mapper.
// master = mapper side, slave = client/sink side.
interface frame_mapper_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_pyld_data;
  logic              i_pyld_data_valid;
  logic              o_pyld_ready;
  logic [DATA_W-1:0] o_frame_data;
  logic              o_frame_data_valid;
  logic              o_frame_data_fas;
  logic              o_underrun;
  logic [DATA_W-1:0] o_mfas;

  modport master (
    input  i_pyld_data, i_pyld_data_valid,
    output o_pyld_ready, o_frame_data, o_frame_data_valid,
           o_frame_data_fas, o_underrun, o_mfas
  );

  modport slave (
    output i_pyld_data, i_pyld_data_valid,
    input  o_pyld_ready, o_frame_data, o_frame_data_valid,
           o_frame_data_fas, o_underrun, o_mfas
  );
endinterface

// File: rtl/frame_mapper.sv
// Free-running frame builder: FAS, overhead, optional MFAS byte, stuff column, payload.
// Optional feature macro: FRAME_MFAS_EN (MFAS slot and multiframe counter).
module frame_mapper #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 1041,
  parameter int OH_COLS  = 16,
  parameter int FAS_LEN  = 3,
  parameter int DATA_W   = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  frame_mapper_if.master bus
);
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [2:0] {
    SLOT_FAS_A = 3'd0,
    SLOT_FAS_B = 3'd1,
    SLOT_MFAS  = 3'd2,
    SLOT_ZERO  = 3'd3,
    SLOT_PYLD  = 3'd4
  } slot_t;

  function automatic slot_t classify(input logic [RW-1:0] row, input logic [CW-1:0] col);
    slot_t s;
    if ((row == '0) && (col < CW'(FAS_LEN))) begin
      s = SLOT_FAS_A;
    end else if ((row == '0) && (col < CW'(2*FAS_LEN))) begin
      s = SLOT_FAS_B;
    end else if ((row == '0) && (col == CW'(2*FAS_LEN))) begin
      s = SLOT_MFAS;
    end else if ((col < CW'(OH_COLS)) || (col == CW'(NUM_COLS-1))) begin
      s = SLOT_ZERO;
    end else begin
      s = SLOT_PYLD;
    end
    return s;
  endfunction

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     w_col_nxt;
  logic [RW-1:0]     w_row_nxt;
  slot_t             w_slot;
  slot_t             w_slot_nxt;
  logic [DATA_W-1:0] w_byte;
  logic [DATA_W-1:0] w_mfas_byte;

  logic [DATA_W-1:0] r_frame_data;
  logic              r_frame_valid;
  logic              r_fas;
  logic              r_underrun;
  logic              r_ready;

  // Next row/column position of the free-running frame counters.
  always_comb begin
    w_col_nxt = r_col + CW'(1);
    w_row_nxt = r_row;
    if (r_col == CW'(NUM_COLS-1)) begin
      w_col_nxt = '0;
      if (r_row == RW'(NUM_ROWS-1)) begin
        w_row_nxt = '0;
      end else begin
        w_row_nxt = r_row + RW'(1);
      end
    end else begin
      w_row_nxt = r_row;
    end
  end

  // Frame position counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  assign w_slot     = classify(r_row, r_col);
  assign w_slot_nxt = classify(w_row_nxt, w_col_nxt);

  // Byte selected for the current slot; a missing client byte becomes zero.
  always_comb begin
    w_byte = '0;
    case (w_slot)
      SLOT_FAS_A: w_byte = DATA_W'(8'hF6);
      SLOT_FAS_B: w_byte = DATA_W'(8'h28);
      SLOT_MFAS:  w_byte = w_mfas_byte;
      SLOT_PYLD: begin
        if (bus.i_pyld_data_valid) begin
          w_byte = bus.i_pyld_data;
        end else begin
          w_byte = '0;
        end
      end
      default:    w_byte = '0;
    endcase
  end

  // Registered stream outputs; ready is decoded one cycle early so it lines up with the counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_fas         <= 1'b0;
      r_underrun    <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_frame_data  <= w_byte;
      r_frame_valid <= 1'b1;
      r_fas         <= (w_slot == SLOT_FAS_A) && (r_col == '0);
      r_underrun    <= (w_slot == SLOT_PYLD) && !bus.i_pyld_data_valid;
      r_ready       <= (w_slot_nxt == SLOT_PYLD);
    end
  end

`ifdef FRAME_MFAS_EN
  logic [DATA_W-1:0] r_mfas;
  logic              w_end_of_frame;

  assign w_end_of_frame = (r_row == RW'(NUM_ROWS-1)) && (r_col == CW'(NUM_COLS-1));

  // Multiframe counter; the MFAS slot of a frame shows the count before that frame ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mfas <= '0;
    end else if (w_end_of_frame) begin
      r_mfas <= r_mfas + DATA_W'(1);
    end
  end

  assign w_mfas_byte = r_mfas;
  assign bus.o_mfas  = r_mfas;
`else
  assign w_mfas_byte = '0;
  assign bus.o_mfas  = '0;
`endif

  assign bus.o_frame_data       = r_frame_data;
  assign bus.o_frame_data_valid = r_frame_valid;
  assign bus.o_frame_data_fas   = r_fas;
  assign bus.o_underrun         = r_underrun;
  assign bus.o_pyld_ready       = r_ready;
endmodule
